sv32_pte_fetch_responder: RTL and testbench
===========================================

SV32_PTE_FETCH_RESPONDER -- requirements
Module: sv32_pte_fetch_responder

Interface
REQ-001 SHALL have parameter PTE_CACHE_ENTRIES, default 8, giving the number of direct-mapped PTE cache lines (power of two, >=2).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port walk_mem_valid  in  1  page-walker read request, held high until walk_mem_ready.
REQ-005 SHALL have port walk_mem_addr  in  32  word-aligned PTE physical address, stable while walk_mem_valid is high.
REQ-006 SHALL have port walk_mem_ready  out  1  one-cycle pulse; walk_mem_rdata is valid in the same cycle.
REQ-007 SHALL have port walk_mem_rdata  out  32  PTE word returned to the walker.
REQ-008 SHALL have port pte_cache_flush  in  1  invalidate all cache lines (sfence.vma / satp write).
REQ-009 SHALL have port mem_valid  out  1  system-memory read request.
REQ-010 SHALL have port mem_addr  out  32  system-memory read address, {walk_mem_addr[31:2],2'b00}.
REQ-011 SHALL have port mem_ready  in  1  system-memory completion; mem_rdata is valid in the same cycle.
REQ-012 SHALL have port mem_rdata  in  32  system-memory read data.

Function
REQ-013 SHALL implement FSM states IDLE, LOOKUP, MEM, RESP.
REQ-014 IDLE: on walk_mem_valid=1, SHALL latch the address and go to LOOKUP; otherwise remain in IDLE.
REQ-015 LOOKUP, hit (line valid, tag match): SHALL assert walk_mem_ready=1 with cached data in that cycle and go to IDLE.
REQ-016 LOOKUP, miss: SHALL go to MEM.
REQ-017 MEM: SHALL hold mem_valid=1 with a stable mem_addr until mem_ready=1; on mem_ready SHALL capture mem_rdata, fill the line, and go to RESP.
REQ-018 RESP: SHALL assert walk_mem_ready=1 with the captured word for exactly one cycle, then go to IDLE.
REQ-019 Latency, counted from the first cycle valid is sampled high: hit = ready in cycle +1; miss = ready 1 cycle after the mem_ready cycle.
REQ-020 walk_mem_valid high in the cycle after a ready pulse SHALL be treated as a new request; a completed request SHALL never be answered twice.
REQ-021 Index SHALL be addr[2+IW-1:2], where IW=log2(PTE_CACHE_ENTRIES); tag SHALL be addr[31:2+IW].
REQ-022 pte_cache_flush SHALL clear every valid bit at the next edge, in any state.
REQ-023 If flush and a fill occur in the same cycle, flush SHALL win and the line SHALL remain invalid; the response SHALL still be delivered.
REQ-024 A LOOKUP cycle coinciding with flush SHALL be treated as a miss.
REQ-025 If walk_mem_valid drops during MEM, the memory read SHALL complete and fill the cache, the response SHALL be suppressed, and the FSM SHALL return to IDLE.
REQ-026 walk_mem_ready and mem_valid SHALL be 0 in every state not named above; walk_mem_rdata SHALL be 0 when walk_mem_ready=0.
REQ-027 The block SHALL be read-only; it SHALL never issue a write.

Reset
REQ-028 Reset SHALL force state=IDLE, all valid bits=0, walk_mem_ready=0, walk_mem_rdata=0, mem_valid=0, mem_addr=0.
REQ-029 Reset asserted mid-MEM SHALL abandon the transaction; any late mem_ready SHALL be ignored in IDLE.

Structure
REQ-030 The state enum and the PTE-cache index/tag width functions SHALL live in shared package sv32_pkg.
REQ-031 Valid/tag/data storage SHALL be a single sub-module, pte_cache_array (flush-clear, one write port, one combinational read port).

Verification
REQ-032 Cold miss: valid, addr=0x8000_1004; mem_ready on the 3rd MEM cycle with rdata=0x2000_0C01 -> mem_addr=0x8000_1004, walk_mem_ready pulses one cycle after mem_ready with rdata=0x2000_0C01.
REQ-033 Hit: repeat addr=0x8000_1004 -> ready in cycle +1, rdata=0x2000_0C01, mem_valid never asserted.
REQ-034 Conflict: addr=0x8000_1024 (same index, different tag) -> miss; a following 0x8000_1004 -> miss again.
REQ-035 Flush: pte_cache_flush=1 for one cycle, then 0x8000_1024 -> miss; flush coincident with mem_ready -> response delivered, next same-address access misses.
REQ-036 Back-to-back: valid held high across ready with the address changing 0x8000_1004->0x8000_2008 -> exactly two responses with the correct data each.
REQ-037 Abort: drop walk_mem_valid mid-MEM -> no ready pulse; reset mid-MEM -> IDLE, all outputs 0, later mem_ready ignored.

Source files
------------

// File: rtl/sv32_pkg.sv
// Shared types and sizing helpers for the SV32 PTE fetch responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   fetch_state_t  - responder FSM states
//   pte_idx_width  - index bits for a given number of cache lines
//   pte_tag_width  - tag bits left above the index in a word address
package sv32_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MEM    = 2'd2,
    RESP   = 2'd3
  } fetch_state_t;

  localparam int PA_W     = 32;
  localparam int WORD_LSB = 2;

  function automatic int pte_idx_width(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int pte_tag_width(input int entries);
    return PA_W - WORD_LSB - $clog2(entries);
  endfunction

endpackage

// File: rtl/pte_cache_array.sv
// Direct-mapped PTE line storage: valid bits, tags and data words.
// Latency: combinational read, write visible after the next clk edge.
// Backpressure: none; a write is accepted every cycle wr_en is high.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset (clears valid bits)
//   flush               - clear every valid bit at the next edge; beats a same-cycle write
//   wr_en/idx/tag/data  - single fill port
//   rd_idx              - combinational read index
//   rd_valid/tag/data   - contents of the addressed line
module pte_cache_array
  import sv32_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = pte_idx_width(ENTRIES),
  parameter int TAG_W   = pte_tag_width(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data
);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags [ENTRIES];
  logic [31:0]        data [ENTRIES];

  // Flush has priority so a fill racing an sfence.vma leaves the line invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/sv32_pte_fetch_responder.sv
// Serves page-walker PTE reads from a small direct-mapped cache, filling from system memory on a miss.
// Latency: hit answers in the cycle after the request is sampled; miss answers the cycle after mem_ready.
// Backpressure: walker holds walk_mem_valid until the ready pulse; memory side holds mem_valid until mem_ready.
//
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   walk_mem_valid/addr             - walker read request (held until walk_mem_ready)
//   walk_mem_ready/rdata            - one-cycle response pulse with PTE word (rdata is 0 otherwise)
//   pte_cache_flush                 - invalidate all lines (sfence.vma / satp write)
//   mem_valid/addr, mem_ready/rdata - read-only system memory port
module sv32_pte_fetch_responder
  import sv32_pkg::*;
#(
  parameter int PTE_CACHE_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        walk_mem_valid,
  input  logic [31:0] walk_mem_addr,
  output logic        walk_mem_ready,
  output logic [31:0] walk_mem_rdata,
  input  logic        pte_cache_flush,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int IW = pte_idx_width(PTE_CACHE_ENTRIES);
  localparam int TW = pte_tag_width(PTE_CACHE_ENTRIES);

  fetch_state_t  state;
  logic [31:0]   addr_q;     // word-aligned request address, doubles as mem_addr
  logic [31:0]   resp_q;     // word captured from memory for the RESP pulse
  logic          abort_q;    // walker dropped its request while memory was busy

  logic [IW-1:0] line_idx;
  logic [TW-1:0] line_tag;
  logic          cached_valid;
  logic [TW-1:0] cached_tag;
  logic [31:0]   cached_data;
  logic          hit;
  logic          fill;

  // Request byte offset is not part of the word address.
  logic          unused_addr_lsbs;
  assign unused_addr_lsbs = ^walk_mem_addr[1:0];

  assign line_idx = addr_q[2 +: IW];
  assign line_tag = addr_q[31:2+IW];

  // A flush in the lookup cycle forces a miss so stale PTEs are never returned.
  assign hit  = (state == LOOKUP) && cached_valid && (cached_tag == line_tag) && !pte_cache_flush;
  assign fill = (state == MEM) && mem_ready;

  pte_cache_array #(
    .ENTRIES (PTE_CACHE_ENTRIES),
    .IDX_W   (IW),
    .TAG_W   (TW)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .flush    (pte_cache_flush),
    .wr_en    (fill),
    .wr_idx   (line_idx),
    .wr_tag   (line_tag),
    .wr_data  (mem_rdata),
    .rd_idx   (line_idx),
    .rd_valid (cached_valid),
    .rd_tag   (cached_tag),
    .rd_data  (cached_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      resp_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (walk_mem_valid) begin
            addr_q <= {walk_mem_addr[31:2], 2'b00};
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            abort_q <= 1'b0;
            state   <= MEM;
          end
        end
        MEM: begin
          // The memory read always runs to completion (and fills); only the
          // walker response is dropped if the request went away meanwhile.
          if (mem_ready) begin
            resp_q <= mem_rdata;
            state  <= (abort_q || !walk_mem_valid) ? IDLE : RESP;
          end else if (!walk_mem_valid) begin
            abort_q <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign walk_mem_ready = hit || (state == RESP);
  assign walk_mem_rdata = hit ? cached_data : ((state == RESP) ? resp_q : 32'd0);
  assign mem_valid      = (state == MEM);
  assign mem_addr       = addr_q;

endmodule

// File: tb/tb_sv32_pte_fetch_responder.sv
module tb_sv32_pte_fetch_responder;

  localparam int ENTRIES = 8;
  localparam int IW      = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        walk_mem_valid;
  logic [31:0] walk_mem_addr;
  logic        walk_mem_ready;
  logic [31:0] walk_mem_rdata;
  logic        pte_cache_flush;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  sv32_pte_fetch_responder #(.PTE_CACHE_ENTRIES(ENTRIES)) dut (
    .clk             (clk),
    .reset           (reset),
    .walk_mem_valid  (walk_mem_valid),
    .walk_mem_addr   (walk_mem_addr),
    .walk_mem_ready  (walk_mem_ready),
    .walk_mem_rdata  (walk_mem_rdata),
    .pte_cache_flush (pte_cache_flush),
    .mem_valid       (mem_valid),
    .mem_addr        (mem_addr),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  int          nchk = 0;
  int          npass = 0;
  int          cyc = 0;
  int          ready_cnt = 0;
  int          mv_cnt = 0;
  int          last_mr_cyc = 0;
  bit          mem_seen = 0;
  int          mem_lat = 1;
  bit          late_pulse = 0;

  // Reference cache: line i holds the word address >> IW of the last fill.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_1004) return 32'h2000_0C01;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int idx;
    idx = int'((a >> 2) % ENTRIES);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = a >> (2 + IW);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = int'((a >> 2) % ENTRIES);
    return m_valid[idx] && (m_tag[idx] == (a >> (2 + IW)));
  endfunction

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: answers after mem_lat cycles of mem_valid (never if mem_lat==0).
  initial begin : responder
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (reset) begin
        cnt = 0;
      end else if (late_pulse) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end else if (mem_valid) begin
        cnt++;
        if (mem_lat != 0 && cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every response pulse.
  initial begin : monitor
    exp_t e;
    int   exp_cyc;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_seen = 1'b0;
      end else begin
        if (mem_valid) begin
          mv_cnt++;
          if (sb.size() != 0) mem_seen = 1'b1;
        end
        if (mem_valid && mem_ready) begin
          last_mr_cyc = cyc;
          if (sb.size() != 0) check("mem_addr", mem_addr, {sb[0].addr[31:2], 2'b00});
        end
        if (walk_mem_ready) begin
          ready_cnt++;
          if (sb.size() == 0) begin
            nchk++;
            $display("FAIL spurious_ready: actual ready=1 rdata=0x%08h required no response (cycle %0d)",
                     walk_mem_rdata, cyc);
          end else begin
            e = sb.pop_front();
            exp_cyc = e.miss ? last_mr_cyc + 1 : e.issue + 1;
            check("rdata", walk_mem_rdata, e.data);
            check("miss_flag", {31'b0, mem_seen}, {31'b0, e.miss});
            check("latency_cycle", cyc, exp_cyc);
            mem_seen = 1'b0;
          end
        end else begin
          check("rdata_idle_zero", walk_mem_rdata, 32'd0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // fmode: 0 none, 1 flush coincident with mem_ready, 2 flush during lookup.
  task automatic do_req(input logic [31:0] a, input int lat, input int fmode, input bit keep);
    exp_t e;
    bit   hit;
    bit   got;
    if (fmode == 2) clear_model();
    hit = model_hit(a);
    if (!hit) begin
      if (fmode == 1) clear_model();
      else model_fill(a);
    end
    e.addr  = a;
    e.data  = mem_word(a);
    e.miss  = !hit;
    e.issue = cyc;
    mem_lat = lat;
    sb.push_back(e);
    walk_mem_valid = 1'b1;
    walk_mem_addr  = a;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (walk_mem_ready) got = 1'b1;
      else if (fmode == 1 && mem_ready) pte_cache_flush = 1'b1;
      @(posedge clk);
      #1;
      pte_cache_flush = (fmode == 2 && i == 0);
      if (got) break;
    end
    if (!got) begin
      nchk++;
      $display("FAIL req_timeout: addr=0x%08h actual no walk_mem_ready required one within 100 cycles", a);
    end
    if (!keep) walk_mem_valid = 1'b0;
  endtask

  task automatic flush_all();
    walk_mem_valid  = 1'b0;
    pte_cache_flush = 1'b1;
    @(posedge clk);
    #1;
    pte_cache_flush = 1'b0;
    clear_model();
  endtask

  task automatic wait_mem_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid) seen = 1'b1;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          rc;
    int          mv;
    bit          seen;
    bit          keep;
    int          fm;
    logic [31:0] a;

    reset           = 1'b1;
    walk_mem_valid  = 1'b0;
    walk_mem_addr   = 32'd0;
    pte_cache_flush = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'b0, walk_mem_ready}, 32'd0);
    check("reset_rdata", walk_mem_rdata, 32'd0);
    check("reset_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Cold miss, hit, conflict.
    do_req(32'h8000_1004, 3, 0, 0); idle(2);
    rc = mv_cnt;
    do_req(32'h8000_1004, 3, 0, 0); idle(1);
    check("hit_no_mem_valid", mv_cnt - rc, 32'd0);
    do_req(32'h8000_1024, 2, 0, 0); idle(1);
    do_req(32'h8000_1004, 2, 0, 0); idle(1);

    // Flush, then flush racing a fill.
    flush_all();
    do_req(32'h8000_1024, 2, 0, 0); idle(1);
    do_req(32'h8000_2008, 2, 1, 0); idle(1);
    do_req(32'h8000_2008, 1, 0, 0); idle(1);
    do_req(32'h8000_2008, 1, 0, 0); idle(1);

    // Back-to-back with valid held across the ready pulse.
    flush_all();
    rc = ready_cnt;
    do_req(32'h8000_1004, 2, 0, 1);
    do_req(32'h8000_2008, 2, 0, 0);
    idle(6);
    check("b2b_response_count", ready_cnt - rc, 32'd2);

    // Flush in the lookup cycle of a line that would hit.
    do_req(32'h8000_2008, 1, 2, 0); idle(1);

    // Walker drops the request mid-MEM: no response, but the line is filled.
    a = 32'h8000_3010;
    mem_lat = 4;
    rc = ready_cnt;
    walk_mem_valid = 1'b1;
    walk_mem_addr  = a;
    wait_mem_valid(seen);
    check("abort_mem_request", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
    walk_mem_valid = 1'b0;
    idle(10);
    check("abort_no_ready", ready_cnt - rc, 32'd0);
    model_fill(a);
    do_req(a, 4, 0, 0); idle(1);

    // Reset mid-MEM, then a late mem_ready in IDLE.
    a = 32'h8000_4014;
    mem_lat = 0;
    walk_mem_valid = 1'b1;
    walk_mem_addr  = a;
    wait_mem_valid(seen);
    check("rst_mem_request", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    walk_mem_valid = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'b0, walk_mem_ready}, 32'd0);
    check("midrst_rdata", walk_mem_rdata, 32'd0);
    check("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    mv = mv_cnt;
    rc = ready_cnt;
    @(negedge clk);
    late_pulse = 1'b1;
    @(negedge clk);
    late_pulse = 1'b0;
    idle(6);
    check("late_ready_no_mem_valid", mv_cnt - mv, 32'd0);
    check("late_ready_no_response", ready_cnt - rc, 32'd0);
    do_req(a, 2, 0, 0); idle(1);
    do_req(a, 2, 0, 0); idle(1);

    // Randomized traffic over a small address pool to mix hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) flush_all();
      a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2);
      fm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      keep = ($urandom_range(0, 2) == 0);
      do_req(a, int'($urandom_range(1, 4)), fm, keep);
      if (!keep) idle(int'($urandom_range(0, 2)));
    end
    walk_mem_valid = 1'b0;
    idle(10);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
